// File: rtl/load_align_unit_if.sv
// Load unit bus bundle: LSU request side, data-memory read port and result port.
// slave is the load unit's view, master is the environment (LSU + memory + consumer).
interface load_align_unit_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [2:0]        req_funct3;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rsp_valid;
    logic [XLEN-1:0]   mem_rdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [XLEN-1:0]   rsp_data;
    logic              rsp_fault;

    modport slave (
        input  req_valid, req_addr, req_funct3, mem_req_ready, mem_rsp_valid, mem_rdata, rsp_ready,
        output req_ready, mem_req_valid, mem_addr, rsp_valid, rsp_data, rsp_fault
    );

    modport master (
        output req_valid, req_addr, req_funct3, mem_req_ready, mem_rsp_valid, mem_rdata, rsp_ready,
        input  req_ready, mem_req_valid, mem_addr, rsp_valid, rsp_data, rsp_fault
    );
endinterface

// File: rtl/load_align_unit.sv
// load_align_unit: one-outstanding load engine. Issues word-aligned bus reads,
// extracts the addressed bytes and sign/zero-extends them to XLEN.
// Build option LOAD_MISALIGN_SPLIT_EN: when defined, loads that cross a word
// boundary are split into two reads; when undefined they fault without bus traffic.
module load_align_unit #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    load_align_unit_if.slave bus
);
    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);

    typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [OW-1:0]     off_q, off_d;
    logic [XLEN-1:0]   rsp_data_q, rsp_data_d;
    logic              rsp_fault_q, rsp_fault_d;
`ifdef LOAD_MISALIGN_SPLIT_EN
    logic              span_q, span_d;
    logic [XLEN-1:0]   lo_q, lo_d;
`endif

    logic [OW-1:0]     req_off;
    logic              req_illegal;
    logic              req_span;

    // Shift the two-word window down by the byte offset, then extend by size/sign.
    function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] hi, input logic [XLEN-1:0] lo,
                                                input logic [OW-1:0] off, input logic [2:0] f3);
        logic [XLEN-1:0] sh;
        logic [XLEN-1:0] r;
        logic            sx;
        sh = XLEN'({hi, lo} >> {off, 3'b000});
        sx = ~f3[2];
        r  = sh;
        case (f3[1:0])
            2'b00: begin r = {XLEN{sx & sh[7]}};  r[7:0]  = sh[7:0];  end
            2'b01: begin r = {XLEN{sx & sh[15]}}; r[15:0] = sh[15:0]; end
            2'b10: begin r = {XLEN{sx & sh[31]}}; r[31:0] = sh[31:0]; end
            default: r = sh;
        endcase
        return r;
    endfunction

    // Decode the incoming request: illegal width/sign combos and word-crossing detection.
    always_comb begin
        req_off     = bus.req_addr[OW-1:0];
        req_illegal = (bus.req_funct3 == 3'b111) ||
                      ((XLEN == 32) && ((bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110)));
        req_span    = (32'(req_off) + (32'd1 << bus.req_funct3[1:0])) > 32'(NB);
    end

    // Next-state and datapath updates; everything holds unless the current state says otherwise.
    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        rsp_data_d  = rsp_data_q;
        rsp_fault_d = rsp_fault_q;
`ifdef LOAD_MISALIGN_SPLIT_EN
        span_d      = span_q;
        lo_d        = lo_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    funct3_d = bus.req_funct3;
                    off_d    = req_off;
`ifdef LOAD_MISALIGN_SPLIT_EN
                    span_d   = req_span;
                    if (req_illegal) begin
`else
                    if (req_illegal || req_span) begin
`endif
                        state_d     = RESP;
                        rsp_fault_d = 1'b1;
                        rsp_data_d  = '0;
                    end else begin
                        state_d    = REQ0;
                        mem_addr_d = {bus.req_addr[ADDR_W-1:OW], {OW{1'b0}}};
                    end
                end
            end
            REQ0: if (bus.mem_req_ready) state_d = WAIT0;
            WAIT0: begin
                if (bus.mem_rsp_valid) begin
`ifdef LOAD_MISALIGN_SPLIT_EN
                    if (span_q) begin
                        lo_d       = bus.mem_rdata;
                        mem_addr_d = mem_addr_q + ADDR_W'(NB);
                        state_d    = REQ1;
                    end else
`endif
                    begin
                        state_d     = RESP;
                        rsp_data_d  = extract('0, bus.mem_rdata, off_q, funct3_q);
                        rsp_fault_d = 1'b0;
                    end
                end
            end
`ifdef LOAD_MISALIGN_SPLIT_EN
            REQ1: if (bus.mem_req_ready) state_d = WAIT1;
            WAIT1: begin
                if (bus.mem_rsp_valid) begin
                    state_d     = RESP;
                    rsp_data_d  = extract(bus.mem_rdata, lo_q, off_q, funct3_q);
                    rsp_fault_d = 1'b0;
                end
            end
`endif
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    rsp_fault_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any load in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_addr_q  <= '0;
            funct3_q    <= '0;
            off_q       <= '0;
            rsp_data_q  <= '0;
            rsp_fault_q <= 1'b0;
`ifdef LOAD_MISALIGN_SPLIT_EN
            span_q      <= 1'b0;
            lo_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            rsp_data_q  <= rsp_data_d;
            rsp_fault_q <= rsp_fault_d;
`ifdef LOAD_MISALIGN_SPLIT_EN
            span_q      <= span_d;
            lo_q        <= lo_d;
`endif
        end
    end

    assign bus.req_ready     = (state_q == IDLE);
    assign bus.mem_req_valid = (state_q == REQ0) || (state_q == REQ1);
    assign bus.mem_addr      = mem_addr_q;
    assign bus.rsp_valid     = (state_q == RESP);
    assign bus.rsp_data      = rsp_data_q;
    assign bus.rsp_fault     = rsp_fault_q;
endmodule
